module_division_control: RTL

Sequencer for the restoring-division datapath. Accepts a start request with dividend/divisor, then runs one restoring iteration per clock, MSB first. Each iteration computes the trial-subtraction sign, commits or restores the partial remainder, and drives enable/index/sign to the quotient-bit register, writing ~sign at the current index. Ends with a one-cycle done pulse and registered quotient/remainder.

---
 rtl/module_division_control_if.sv | 36 +++
 rtl/module_division_control.sv | 138 +++++++++++++
 2 files changed

// File: rtl/module_division_control_if.sv
//------------------------------------------------------------------------------
// module_division_control_if : start/operand request, status and quotient-bit
// strobe bundle for the restoring-division sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface module_division_control_if #(
  parameter int WIDTH = 4
);
  localparam int IDX_W = $clog2(WIDTH);

  logic             start;
  logic [WIDTH-1:0] dividendo;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] cociente;
  logic [WIDTH-1:0] residuo;
  logic             q_en;
  logic [IDX_W-1:0] q_idx;
  logic             q_signo;

  modport master (
    output start, dividendo, divisor,
    input  busy, done, err, cociente, residuo, q_en, q_idx, q_signo
  );

  modport slave (
    input  start, dividendo, divisor,
    output busy, done, err, cociente, residuo, q_en, q_idx, q_signo
  );
endinterface

`default_nettype wire

// File: rtl/module_division_control.sv
//------------------------------------------------------------------------------
// module_division_control : restoring-division sequencer, one quotient bit per
// clock, MSB first. Optional macro DIV_ERR_EN adds a divide-by-zero short cut.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module module_division_control #(
  parameter int WIDTH = 4
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  module_division_control_if.slave  bus
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_coc;
  logic [WIDTH-1:0] r_res;
`ifdef DIV_ERR_EN
  logic             r_err;
`endif

  logic             w_bit;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH:0]   w_diff;
  logic             w_signo;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_iter;

  // Trial subtraction for the current bit; the extra MSB of w_diff is the borrow.
  assign w_bit     = r_dvd[r_idx];
  assign w_t       = {r_rem[WIDTH-2:0], w_bit};
  assign w_diff    = {1'b0, w_t} - {1'b0, r_dvs};
  assign w_signo   = w_diff[WIDTH];
  assign w_rem_nxt = w_signo ? w_t : w_diff[WIDTH-1:0];
  assign w_iter    = (r_state == S_ITER);

  always_comb begin
    w_q_nxt        = r_q;
    w_q_nxt[r_idx] = ~w_signo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_idx   <= '0;
      r_coc   <= '0;
      r_res   <= '0;
`ifdef DIV_ERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_dvd   <= bus.dividendo;
            r_dvs   <= bus.divisor;
            r_rem   <= '0;
            r_q     <= '0;
`ifdef DIV_ERR_EN
            r_err   <= 1'b0;
`endif
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
`ifdef DIV_ERR_EN
          if (r_dvs == '0) begin
            r_err   <= 1'b1;
            r_coc   <= '1;
            r_res   <= r_dvd;
            r_state <= S_DONE;
          end else begin
            r_idx   <= IDX_W'(WIDTH - 1);
            r_state <= S_ITER;
          end
`else
          r_idx   <= IDX_W'(WIDTH - 1);
          r_state <= S_ITER;
`endif
        end
        S_ITER: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          if (r_idx == '0) begin
            // Last bit: publish the results from the same-edge next values.
            r_coc   <= w_q_nxt;
            r_res   <= w_rem_nxt;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx - IDX_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.cociente = r_coc;
  assign bus.residuo  = r_res;
  assign bus.q_en     = w_iter;
  assign bus.q_idx    = w_iter ? r_idx : '0;
  assign bus.q_signo  = w_iter & w_signo;
`ifdef DIV_ERR_EN
  assign bus.err      = r_err;
`else
  assign bus.err      = 1'b0;
`endif

endmodule

`default_nettype wire
